// File: rtl/mips_pkg.sv
// Shared MIPS encodings used by the EX-stage HI/LO multiply/divide unit.
package mips_pkg;

  localparam logic [5:0] OP_SPECIAL = 6'b000000;

  localparam logic [5:0] FN_MTHI  = 6'b010001;
  localparam logic [5:0] FN_MTLO  = 6'b010011;
  localparam logic [5:0] FN_MULT  = 6'b011000;
  localparam logic [5:0] FN_MULTU = 6'b011001;
  localparam logic [5:0] FN_DIV   = 6'b011010;
  localparam logic [5:0] FN_DIVU  = 6'b011011;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2
  } muldiv_state_t;

endpackage

// File: rtl/muldiv_iter.sv
// Iterative datapath: shift-add multiply and restoring divide, one bit per cycle,
// with combinational sign fixup of the final result.
module muldiv_iter #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            step,
  input  logic            is_div,
  input  logic            is_signed,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            last,
  output logic [XLEN-1:0] res_hi,
  output logic [XLEN-1:0] res_lo
);

  localparam int CW = $clog2(XLEN);

  logic            div_q;
  logic            neg_res;
  logic            neg_rem;
  logic            div_zero;
  logic [CW-1:0]   cnt;
  logic [XLEN-1:0] operand;
  logic [2*XLEN-1:0] acc;
  logic [XLEN:0]   rem;
  logic [XLEN-1:0] quo;

  logic            a_neg;
  logic            b_neg;
  logic [XLEN-1:0] a_abs;
  logic [XLEN-1:0] b_abs;

  assign a_neg = is_signed & a[XLEN-1];
  assign b_neg = is_signed & b[XLEN-1];
  assign a_abs = a_neg ? -a : a;
  assign b_abs = b_neg ? -b : b;

  logic [XLEN:0]   mul_sum;
  logic [XLEN+1:0] div_shift;
  logic [XLEN:0]   div_diff;
  logic            div_ge;

  assign mul_sum   = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, operand} : '0);
  assign div_shift = {rem, quo[XLEN-1]};
  assign div_diff  = div_shift[XLEN:0] - {1'b0, operand};
  assign div_ge    = div_shift >= {2'b00, operand};

  // Multiply: acc low half starts as the multiplier and drains out as the
  // product shifts in. Divide: quo starts as the dividend and fills with quotient bits.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    if (!rst_n) begin
      div_q    <= 1'b0;
      neg_res  <= 1'b0;
      neg_rem  <= 1'b0;
      div_zero <= 1'b0;
      cnt      <= '0;
      operand  <= '0;
      acc      <= '0;
      rem      <= '0;
      quo      <= '0;
    end else if (start) begin
      div_q    <= is_div;
      neg_res  <= a_neg ^ b_neg;
      neg_rem  <= a_neg;
      div_zero <= is_div & (b == '0);
      cnt      <= '0;
      operand  <= is_div ? b_abs : a_abs;
      acc      <= {{XLEN{1'b0}}, b_abs};
      rem      <= '0;
      quo      <= a_abs;
    end else if (step) begin
      cnt <= cnt + 1'b1;
      if (div_q) begin
        rem <= div_ge ? div_diff : div_shift[XLEN:0];
        quo <= {quo[XLEN-2:0], div_ge};
      end else begin
        acc <= {mul_sum, acc[XLEN-1:1]};
      end
    end
  end

  assign last = (cnt == CW'(XLEN - 1));

  logic [2*XLEN-1:0] prod;
  logic [XLEN-1:0]   q_fix;
  logic [XLEN-1:0]   r_fix;

  // A zero divisor leaves rem == |dividend|, so re-applying the dividend sign
  // returns the raw rs value in HI.
  assign prod  = neg_res ? -acc : acc;
  assign q_fix = div_zero ? '1 : (neg_res ? -quo : quo);
  assign r_fix = neg_rem ? -rem[XLEN-1:0] : rem[XLEN-1:0];

  assign res_hi = div_q ? r_fix : prod[2*XLEN-1:XLEN];
  assign res_lo = div_q ? q_fix : prod[XLEN-1:0];

endmodule

// File: rtl/hilo_muldiv_unit.sv
// EX-stage HI/LO owner: MTHI/MTLO writes, iterative mul/div FSM, flush handling.
module hilo_muldiv_unit
  import mips_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            valid,
  input  logic [5:0]      op,
  input  logic [5:0]      func,
  input  logic [XLEN-1:0] rs_val,
  input  logic [XLEN-1:0] rt_val,
  input  logic            flush,
  output logic [XLEN-1:0] hi,
  output logic [XLEN-1:0] lo,
  output logic            busy,
  output logic            done
);

  muldiv_state_t state;

  logic accept;
  logic is_md;
  logic is_div;
  logic is_signed;
  logic last;
  logic [XLEN-1:0] res_hi;
  logic [XLEN-1:0] res_lo;

  assign accept    = valid & (op == OP_SPECIAL) & (state == IDLE) & ~flush;
  assign is_md     = (func == FN_MULT) | (func == FN_MULTU) | (func == FN_DIV) | (func == FN_DIVU);
  assign is_div    = (func == FN_DIV) | (func == FN_DIVU);
  assign is_signed = (func == FN_MULT) | (func == FN_DIV);

  muldiv_iter #(.XLEN(XLEN)) u_iter (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (accept & is_md),
    .step      (state == RUN),
    .is_div    (is_div),
    .is_signed (is_signed),
    .a         (rs_val),
    .b         (rt_val),
    .last      (last),
    .res_hi    (res_hi),
    .res_lo    (res_lo)
  );

  // Flush kills the FIX write as well, so the pulse is masked combinationally.
  assign done = (state == FIX) & ~flush;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      busy  <= 1'b0;
      hi    <= '0;
      lo    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            if (func == FN_MTHI) hi <= rs_val;
            if (func == FN_MTLO) lo <= rs_val;
            if (is_md) begin
              state <= RUN;
              busy  <= 1'b1;
            end
          end
        end
        RUN: begin
          if (flush) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else if (last) begin
            state <= FIX;
          end
        end
        FIX: begin
          if (!flush) begin
            hi <= res_hi;
            lo <= res_lo;
          end
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
